donut_ascii_framer: RTL

//   Upstream feeder for the UART transmitter. Takes a stream of 4-bit luminance pixels from the

---
 rtl/donut_pkg.sv | 30 +++
 rtl/donut_ascii_framer_if.sv | 32 +++
 rtl/donut_glyph_lut.sv | 18 +
 rtl/donut_ascii_framer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/donut_pkg.sv
// Shared constants and types for the donut ASCII framer: byte codes, the glyph palette
// and the framer state encoding.
package donut_pkg;

  localparam logic [7:0] ChEsc   = 8'h1B;
  localparam logic [7:0] ChLbr   = 8'h5B;
  localparam logic [7:0] ChHome  = 8'h48;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChAt    = 8'h40;
  localparam logic [7:0] ChSpace = 8'h20;

  localparam int unsigned NumGlyphs = 12;

  // Darkest to brightest: " .,-~:;=!*#$@ "
  localparam logic [7:0] GlyphTable [NumGlyphs] = '{
    8'h2E, 8'h2C, 8'h2D, 8'h7E, 8'h3A, 8'h3B,
    8'h3D, 8'h21, 8'h2A, 8'h23, 8'h24, 8'h40
  };

  typedef enum logic [2:0] {
    StHome0,
    StHome1,
    StHome2,
    StPix,
    StCr,
    StLf
  } framer_state_e;

endpackage

// File: rtl/donut_ascii_framer_if.sv
// Pixel input and transmitter output bundle of the framer; master is the framer side.
interface donut_ascii_framer_if;

  logic       pix_valid;
  logic [3:0] pix_lum;
  logic       pix_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_txe;
  logic       frame_done;

  modport master (
    input  pix_valid,
    input  pix_lum,
    output pix_ready,
    output tx_start,
    output tx_data,
    input  tx_txe,
    output frame_done
  );

  modport slave (
    output pix_valid,
    output pix_lum,
    input  pix_ready,
    input  tx_start,
    input  tx_data,
    output tx_txe,
    input  frame_done
  );

endinterface

// File: rtl/donut_glyph_lut.sv
// Combinational luminance-to-ASCII palette lookup.
module donut_glyph_lut
  import donut_pkg::*;
(
  input  logic [3:0] lum,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = ChAt;
    if (lum < 4'(NumGlyphs)) begin
      glyph = GlyphTable[lum];
    end else if (lum == 4'hF) begin
      glyph = ChSpace;
    end
  end

endmodule

// File: rtl/donut_ascii_framer.sv
// Converts a luminance pixel stream into ASCII bytes framed with ESC [ H per frame and
// CR LF per row, feeding a start/data/txe transmitter through a one-byte holding register.
module donut_ascii_framer
  import donut_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  donut_ascii_framer_if.master  bus
);

  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);

  framer_state_e   state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            obuf_valid_q, obuf_valid_d;
  logic [7:0]      obuf_data_q, obuf_data_d;
  logic            last_lf_q, last_lf_d;
  logic            frame_done_q, frame_done_d;

  logic       load_ok;
  logic       consume;
  logic       load_en;
  logic [7:0] load_byte;
  logic [7:0] pix_glyph;

  donut_glyph_lut u_glyph_lut (
    .lum   (bus.pix_lum),
    .glyph (pix_glyph)
  );

  // The holding register may be refilled in the same cycle it is drained.
  assign load_ok = !obuf_valid_q || bus.tx_txe;
  assign consume = obuf_valid_q && bus.tx_txe;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    load_en   = 1'b0;
    load_byte = ChEsc;

    case (state_q)
      StHome0: begin
        load_byte = ChEsc;
        load_en   = load_ok;
        if (load_en) state_d = StHome1;
      end
      StHome1: begin
        load_byte = ChLbr;
        load_en   = load_ok;
        if (load_en) state_d = StHome2;
      end
      StHome2: begin
        load_byte = ChHome;
        load_en   = load_ok;
        if (load_en) state_d = StPix;
      end
      StPix: begin
        load_byte = pix_glyph;
        load_en   = load_ok && bus.pix_valid;
        if (load_en) begin
          if (col_q == ColLast) begin
            col_d   = '0;
            state_d = StCr;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StCr: begin
        load_byte = ChCr;
        load_en   = load_ok;
        if (load_en) state_d = StLf;
      end
      StLf: begin
        load_byte = ChLf;
        load_en   = load_ok;
        if (load_en) begin
          if (row_q == RowLast) begin
            row_d   = '0;
            state_d = StHome0;
          end else begin
            row_d   = row_q + RowW'(1);
            state_d = StPix;
          end
        end
      end
      default: state_d = StHome0;
    endcase
  end

  always_comb begin
    obuf_valid_d = obuf_valid_q;
    obuf_data_d  = obuf_data_q;
    last_lf_d    = last_lf_q;
    if (load_en) begin
      obuf_valid_d = 1'b1;
      obuf_data_d  = load_byte;
      last_lf_d    = (state_q == StLf) && (row_q == RowLast);
    end else if (consume) begin
      obuf_valid_d = 1'b0;
      obuf_data_d  = 8'h00;
      last_lf_d    = 1'b0;
    end
    // last_lf_q tags the byte currently held, so this fires only when the frame's final LF leaves.
    frame_done_d = consume && last_lf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHome0;
      col_q        <= '0;
      row_q        <= '0;
      obuf_valid_q <= 1'b0;
      obuf_data_q  <= 8'h00;
      last_lf_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      obuf_valid_q <= obuf_valid_d;
      obuf_data_q  <= obuf_data_d;
      last_lf_q    <= last_lf_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = (state_q == StPix) && load_ok;
  assign bus.tx_start   = obuf_valid_q;
  assign bus.tx_data    = obuf_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
